// File: rtl/dispatch_pkg.sv
// Shared types and defaults for the dual-lane word dispatcher.
package dispatch_pkg;

   typedef enum logic {
      LANE_A = 1'b0,
      LANE_B = 1'b1
   } lane_e;

   localparam int DEF_WORD_W = 32;
   localparam int DEF_CNT_W  = 16;

endpackage : dispatch_pkg

// File: rtl/lane_slot.sv
// One-entry registered output slot with valid/ready handshake and a wrapping
// count of words loaded since reset or flush.
module lane_slot
   import dispatch_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              load,
   input  logic [WORD_W-1:0] load_data,
   input  logic              ready,
   output logic              valid,
   output logic [WORD_W-1:0] data,
   output logic [CNT_W-1:0]  count,
   output logic              can_accept
);

   logic              valid_r;
   logic [WORD_W-1:0] data_r;
   logic [CNT_W-1:0]  count_r;

   // A slot can take a word when empty or when its current word leaves this edge.
   always_comb begin
      can_accept = (!valid_r) || ready;
   end

   // Slot state: flush clears valid and count but leaves the data register alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         data_r  <= '0;
         count_r <= '0;
      end else if (flush) begin
         valid_r <= 1'b0;
         count_r <= '0;
      end else if (load) begin
         valid_r <= 1'b1;
         data_r  <= load_data;
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (valid_r && ready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign valid = valid_r;
   assign data  = data_r;
   assign count = count_r;

endmodule : lane_slot

// File: rtl/dual_lane_dispatcher.sv
// Splits a valid/ready word stream across two registered output lanes, either
// in strict A/B alternation or preferring the pointer lane and falling back.
module dual_lane_dispatcher
   import dispatch_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int STRICT = 1,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              a_valid,
   input  logic              a_ready,
   output logic [WORD_W-1:0] a_data,
   output logic              b_valid,
   input  logic              b_ready,
   output logic [WORD_W-1:0] b_data,
   output logic [CNT_W-1:0]  a_count,
   output logic [CNT_W-1:0]  b_count
);

   lane_e ptr_r;
   lane_e ptr_nxt_s;
   lane_e target_s;
   logic  can_a_s;
   logic  can_b_s;
   logic  can_ptr_s;
   logic  can_other_s;
   logic  ready_s;
   logic  accept_s;
   logic  load_a_s;
   logic  load_b_s;

   // Target lane and input readiness; flush blocks any acceptance.
   always_comb begin
      can_ptr_s   = (ptr_r == LANE_A) ? can_a_s : can_b_s;
      can_other_s = (ptr_r == LANE_A) ? can_b_s : can_a_s;
      target_s    = ptr_r;
      ready_s     = 1'b0;
      if (flush) begin
         ready_s = 1'b0;
      end else if (STRICT != 0) begin
         ready_s = can_ptr_s;
      end else begin
         if (can_ptr_s) begin
            target_s = ptr_r;
         end else if (can_other_s) begin
            target_s = (ptr_r == LANE_A) ? LANE_B : LANE_A;
         end else begin
            target_s = ptr_r;
         end
         ready_s = can_a_s || can_b_s;
      end
      accept_s = in_valid && ready_s;
      load_a_s = accept_s && (target_s == LANE_A);
      load_b_s = accept_s && (target_s == LANE_B);
   end

   // Pointer next state: points at the lane opposite the one just loaded.
   always_comb begin
      ptr_nxt_s = ptr_r;
      if (flush) begin
         ptr_nxt_s = LANE_A;
      end else if (accept_s) begin
         case (target_s)
            LANE_A:  ptr_nxt_s = LANE_B;
            LANE_B:  ptr_nxt_s = LANE_A;
            default: ptr_nxt_s = LANE_A;
         endcase
      end else begin
         ptr_nxt_s = ptr_r;
      end
   end

   // Pointer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= LANE_A;
      end else begin
         ptr_r <= ptr_nxt_s;
      end
   end

   lane_slot #(
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W)
   ) u_lane_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .load       (load_a_s),
      .load_data  (in_data),
      .ready      (a_ready),
      .valid      (a_valid),
      .data       (a_data),
      .count      (a_count),
      .can_accept (can_a_s)
   );

   lane_slot #(
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W)
   ) u_lane_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .load       (load_b_s),
      .load_data  (in_data),
      .ready      (b_ready),
      .valid      (b_valid),
      .data       (b_data),
      .count      (b_count),
      .can_accept (can_b_s)
   );

   assign in_ready = ready_s;

endmodule : dual_lane_dispatcher

// File: tb/tb_dual_lane_dispatcher.sv
// Scoreboard bench: two dispatchers (strict/16-bit counts and flexible/4-bit counts).
module tb_dual_lane_dispatcher;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush0, flush1;
   logic        in_valid0, in_valid1;
   logic        in_ready0, in_ready1;
   logic [31:0] in_data0, in_data1;
   logic        a_valid0, a_valid1, b_valid0, b_valid1;
   logic        a_ready0, a_ready1, b_ready0, b_ready1;
   logic [31:0] a_data0, a_data1, b_data0, b_data1;
   logic [15:0] a_count0, b_count0;
   logic [3:0]  a_count1, b_count1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] q0a[$], q0b[$], q1a[$], q1b[$];

   always #5 clk = ~clk;

   dual_lane_dispatcher #(.WORD_W(32), .STRICT(1), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush0),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
      .a_valid(a_valid0), .a_ready(a_ready0), .a_data(a_data0),
      .b_valid(b_valid0), .b_ready(b_ready0), .b_data(b_data0),
      .a_count(a_count0), .b_count(b_count0)
   );

   dual_lane_dispatcher #(.WORD_W(32), .STRICT(0), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush1),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .a_valid(a_valid1), .a_ready(a_ready1), .a_data(a_data1),
      .b_valid(b_valid1), .b_ready(b_ready1), .b_data(b_data1),
      .a_count(a_count1), .b_count(b_count1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Scoreboard: every word leaving a lane must be the next one expected there.
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_valid0 && a_ready0) begin
            if (q0a.size() == 0) check("dut0_a_unexpected", 32'd1, 32'd0);
            else check("dut0_a_data", a_data0, q0a.pop_front());
         end
         if (b_valid0 && b_ready0) begin
            if (q0b.size() == 0) check("dut0_b_unexpected", 32'd1, 32'd0);
            else check("dut0_b_data", b_data0, q0b.pop_front());
         end
         if (a_valid1 && a_ready1) begin
            if (q1a.size() == 0) check("dut1_a_unexpected", 32'd1, 32'd0);
            else check("dut1_a_data", a_data1, q1a.pop_front());
         end
         if (b_valid1 && b_ready1) begin
            if (q1b.size() == 0) check("dut1_b_unexpected", 32'd1, 32'd0);
            else check("dut1_b_data", b_data1, q1b.pop_front());
         end
      end
   end

   // Offer one word (called and returning at posedge+1); expected lane goes to the scoreboard.
   task automatic send(input int inst, input logic [31:0] d, input bit to_b, output int waited);
      bit done = 1'b0;
      bit rdy;
      waited = 0;
      if (inst == 0) begin in_valid0 = 1'b1; in_data0 = d; end
      else begin in_valid1 = 1'b1; in_data1 = d; end
      while (!done) begin
         @(negedge clk);
         rdy = (inst == 0) ? in_ready0 : in_ready1;
         if (rdy) begin
            done = 1'b1;
            if (inst == 0 && !to_b) q0a.push_back(d);
            else if (inst == 0) q0b.push_back(d);
            else if (!to_b) q1a.push_back(d);
            else q1b.push_back(d);
         end else begin
            waited++;
            if (waited > 50) begin
               check("send_timeout", 32'd0, 32'd1);
               done = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int w;
      int wsum;
      rst_n = 1'b0;
      flush0 = 1'b0; flush1 = 1'b0;
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      in_data0 = 32'd0; in_data1 = 32'd0;
      a_ready0 = 1'b1; b_ready0 = 1'b1; a_ready1 = 1'b1; b_ready1 = 1'b1;
      idle(3);
      check("rst_a_valid0", {31'd0, a_valid0}, 32'd0);
      check("rst_a_data0", a_data0, 32'd0);
      check("rst_count0", {a_count0, b_count0}, 32'd0);
      rst_n = 1'b1;
      idle(1);
      check("rst_in_ready0", {31'd0, in_ready0}, 32'd1);

      // Strict ping-pong, full throughput.
      wsum = 0;
      send(0, 32'h11, 1'b0, w); wsum += w;
      send(0, 32'h22, 1'b1, w); wsum += w;
      send(0, 32'h33, 1'b0, w); wsum += w;
      send(0, 32'h44, 1'b1, w); wsum += w;
      in_valid0 = 1'b0;
      check("strict_no_stall", wsum, 32'd0);
      idle(2);
      check("strict_a_count", {16'd0, a_count0}, 32'd2);
      check("strict_b_count", {16'd0, b_count0}, 32'd2);

      // Reset in the middle of a transfer with both slots full.
      a_ready0 = 1'b0; b_ready0 = 1'b0;
      send(0, 32'h99, 1'b0, w);
      send(0, 32'h98, 1'b1, w);
      in_valid0 = 1'b1; in_data0 = 32'h97;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", {30'd0, a_valid0, b_valid0}, 32'd0);
      check("midrst_counts", {a_count0, b_count0}, 32'd0);
      in_valid0 = 1'b0;
      q0a.delete(); q0b.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", {31'd0, in_ready0}, 32'd1);
      @(posedge clk); #1;

      // Strict stall on a blocked pointer lane, then refill on the draining edge.
      b_ready0 = 1'b1;
      send(0, 32'hA1, 1'b0, w);
      send(0, 32'hB1, 1'b1, w);
      in_valid0 = 1'b1; in_data0 = 32'hAA;
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready0}, 32'd0);
      @(negedge clk);
      check("stall_b_idle", {31'd0, b_valid0}, 32'd0);
      check("stall_a_hold", a_data0, 32'hA1);
      @(posedge clk); #1;
      a_ready0 = 1'b1;
      send(0, 32'hAA, 1'b0, w);
      in_valid0 = 1'b0;
      check("refill_wait", w, 32'd0);
      @(negedge clk);
      check("refill_a_valid", {31'd0, a_valid0}, 32'd1);
      check("refill_a_data", a_data0, 32'hAA);
      @(posedge clk); #1;

      // Flush with both slots full and a word on offer.
      a_ready0 = 1'b0; b_ready0 = 1'b0;
      send(0, 32'hF1, 1'b1, w);
      send(0, 32'hF2, 1'b0, w);
      in_valid0 = 1'b1; in_data0 = 32'h66; flush0 = 1'b1;
      @(negedge clk);
      check("flush_in_ready", {31'd0, in_ready0}, 32'd0);
      @(posedge clk); #1;
      flush0 = 1'b0; in_valid0 = 1'b0;
      q0a.delete(); q0b.delete();
      check("flush_valid", {30'd0, a_valid0, b_valid0}, 32'd0);
      check("flush_counts", {a_count0, b_count0}, 32'd0);
      a_ready0 = 1'b1; b_ready0 = 1'b1;
      send(0, 32'h77, 1'b0, w);
      in_valid0 = 1'b0;
      check("flush_next_a", {16'd0, a_count0}, 32'd1);
      idle(2);

      // Flexible mode: blocked pointer lane falls back to the other, pointer stays.
      a_ready1 = 1'b0; b_ready1 = 1'b1;
      send(1, 32'h50, 1'b0, w);
      send(1, 32'h51, 1'b1, w);
      send(1, 32'h55, 1'b1, w);
      in_valid1 = 1'b0;
      a_ready1 = 1'b1;
      idle(2);
      send(1, 32'h57, 1'b0, w);
      in_valid1 = 1'b0;
      idle(2);
      check("flex_counts", {24'd0, a_count1, b_count1}, 32'h22);

      // Counter wrap: 17 words into A while B is held full.
      flush1 = 1'b1;
      idle(1);
      flush1 = 1'b0;
      q1a.delete(); q1b.delete();
      a_ready1 = 1'b1; b_ready1 = 1'b0;
      send(1, 32'h600, 1'b0, w);
      send(1, 32'h601, 1'b1, w);
      wsum = 0;
      for (int i = 2; i < 18; i++) begin
         send(1, 32'h600 + i, 1'b0, w);
         wsum += w;
      end
      in_valid1 = 1'b0;
      check("wrap_no_stall", wsum, 32'd0);
      idle(2);
      check("wrap_a_count", {28'd0, a_count1}, 32'd1);
      check("wrap_b_count", {28'd0, b_count1}, 32'd1);
      b_ready1 = 1'b1;
      idle(3);
      check("sb_empty", q0a.size() + q0b.size() + q1a.size() + q1b.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dual_lane_dispatcher
